// File: rtl/core_seq.sv
// core_seq: sequencer for one attention pass on the MAC core.
// A pass writes n_q Q rows and n_k K rows into SRAM, loads K into the array,
// streams Q through it, waits for the pipeline to drain, then moves partial
// sums through OFIFO -> PMEM, accumulates, and normalises (divides) each row.
//
// Ports:
//   clk_i      sole clock
//   reset_i    synchronous active-high reset
//   start_i    one-cycle pass request, only honoured in IDLE with legal sizes
//   n_q_i      Q row count, 1..8, latched on accepted start
//   n_k_i      K row count, 1..8, latched on accepted start
//   mem_req_o  external source must present the next Q/K word
//   busy_o     sequencer is not idle
//   done_o     one-cycle pulse on the final cycle of a pass
//   inst_o     core instruction word
//
// All outputs are registered from the current state, so they trail the state
// register by one cycle; done_o therefore lands one cycle after the DONE state.
//
// state   | meaning
// IDLE    | waiting for a legal start
// QWR     | write Q rows into qmem
// KWR     | write K rows into kmem
// KLOAD   | read kmem and shift K into the array (kload trails read by 1)
// EXEC    | read qmem and execute (execute trails read by 1)
// DRAIN_W | wait DRAIN cycles for the MAC pipeline to empty
// OFIFO   | pop OFIFO into pmem (write trails pop by 1)
// ACC     | read pmem and accumulate (acc trails read by 1)
// DIV     | per row: read, divide, write back through the SFP path
// DONE    | single completion cycle

module core_seq #(
  parameter int unsigned DRAIN = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  n_q_i,
  input  logic [3:0]  n_k_i,
  output logic        mem_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [19:0] inst_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_KLOAD, S_EXEC, S_DRAIN_W, S_OFIFO, S_ACC, S_DIV, S_DONE
  } state_e;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN - 1);

  state_e      state_q, state_d;
  logic [2:0]  i_q, i_d;
  // tail marks the extra trailing cycle of the two-phase (read then use) states,
  // which keeps the row counter at 3 bits even when a phase lasts 9 cycles
  logic        tail_q, tail_d;
  logic [1:0]  sub_q, sub_d;
  logic [7:0]  drain_q, drain_d;
  logic [2:0]  nq_m1_q, nq_m1_d;
  logic [2:0]  nk_m1_q, nk_m1_d;

  logic [19:0] inst_d;
  logic        mem_req_d;
  logic        done_d;

  logic        start_ok;
  assign start_ok = start_i &&
                    (n_q_i != 4'd0) && (n_q_i <= 4'd8) &&
                    (n_k_i != 4'd0) && (n_k_i <= 4'd8);

  // state and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      tail_q    <= 1'b0;
      sub_q     <= '0;
      drain_q   <= '0;
      nq_m1_q   <= '0;
      nk_m1_q   <= '0;
      inst_o    <= '0;
      mem_req_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      tail_q    <= tail_d;
      sub_q     <= sub_d;
      drain_q   <= drain_d;
      nq_m1_q   <= nq_m1_d;
      nk_m1_q   <= nk_m1_d;
      inst_o    <= inst_d;
      mem_req_o <= mem_req_d;
      busy_o    <= (state_q != S_IDLE);
      done_o    <= done_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    tail_d  = tail_q;
    sub_d   = sub_q;
    drain_d = drain_q;
    nq_m1_d = nq_m1_q;
    nk_m1_d = nk_m1_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_QWR;
          i_d     = '0;
          tail_d  = 1'b0;
          sub_d   = '0;
          nq_m1_d = 3'(n_q_i - 4'd1);
          nk_m1_d = 3'(n_k_i - 4'd1);
        end
      end
      S_QWR: begin
        if (i_q == nq_m1_q) begin
          state_d = S_KWR;
          i_d     = '0;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      S_KWR: begin
        if (i_q == nk_m1_q) begin
          state_d = S_KLOAD;
          i_d     = '0;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      S_KLOAD: begin
        if (tail_q) begin
          state_d = S_EXEC;
          i_d     = '0;
          tail_d  = 1'b0;
        end else if (i_q == nk_m1_q) begin
          tail_d = 1'b1;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      S_EXEC: begin
        if (tail_q) begin
          state_d = S_DRAIN_W;
          i_d     = '0;
          tail_d  = 1'b0;
          drain_d = DRAIN_LOAD;
        end else if (i_q == nq_m1_q) begin
          tail_d = 1'b1;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      S_DRAIN_W: begin
        if (drain_q == 8'd0) begin
          state_d = S_OFIFO;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      S_OFIFO, S_ACC: begin
        if (tail_q) begin
          state_d = (state_q == S_OFIFO) ? S_ACC : S_DIV;
          i_d     = '0;
          tail_d  = 1'b0;
          sub_d   = '0;
        end else if (i_q == nq_m1_q) begin
          tail_d = 1'b1;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      S_DIV: begin
        if (sub_q == 2'd2) begin
          sub_d = '0;
          if (i_q == nq_m1_q) begin
            state_d = S_DONE;
            i_d     = '0;
          end else begin
            i_d = i_q + 3'd1;
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // output decode; inst bits 15 and 11 stay zero because row indices fit in 3 bits
  always_comb begin
    logic       sfp, acc, div, ofifo_rd, execute, kload;
    logic       qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr;
    logic [2:0] qk_add, p_add;
    sfp      = 1'b0;
    acc      = 1'b0;
    div      = 1'b0;
    ofifo_rd = 1'b0;
    execute  = 1'b0;
    kload    = 1'b0;
    qmem_rd  = 1'b0;
    qmem_wr  = 1'b0;
    kmem_rd  = 1'b0;
    kmem_wr  = 1'b0;
    pmem_rd  = 1'b0;
    pmem_wr  = 1'b0;
    qk_add   = '0;
    p_add    = '0;
    done_d   = 1'b0;
    case (state_q)
      S_QWR: begin
        qmem_wr = 1'b1;
        qk_add  = i_q;
      end
      S_KWR: begin
        kmem_wr = 1'b1;
        qk_add  = i_q;
      end
      S_KLOAD: begin
        kmem_rd = !tail_q;
        kload   = tail_q || (i_q != 3'd0);
        qk_add  = tail_q ? 3'd0 : i_q;
      end
      S_EXEC: begin
        qmem_rd = !tail_q;
        execute = tail_q || (i_q != 3'd0);
        qk_add  = tail_q ? 3'd0 : i_q;
      end
      S_OFIFO: begin
        // the tail cycle writes the last popped row, which is i itself
        ofifo_rd = !tail_q;
        pmem_wr  = tail_q || (i_q != 3'd0);
        if (tail_q)              p_add = i_q;
        else if (i_q != 3'd0)    p_add = i_q - 3'd1;
      end
      S_ACC: begin
        pmem_rd = !tail_q;
        acc     = tail_q || (i_q != 3'd0);
        p_add   = tail_q ? 3'd0 : i_q;
      end
      S_DIV: begin
        case (sub_q)
          2'd0: begin
            pmem_rd = 1'b1;
            p_add   = i_q;
          end
          2'd1: div = 1'b1;
          default: begin
            pmem_wr = 1'b1;
            sfp     = 1'b1;
            p_add   = i_q;
          end
        endcase
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
    mem_req_d = qmem_wr || kmem_wr;
    inst_d = {sfp, acc, div, ofifo_rd, 1'b0, qk_add, 1'b0, p_add,
              execute, kload, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr};
  end

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: a pass-level model builds the expected instruction
// stream from the pass rules, and each cycle of the DUT is compared to it.
module tb_core_seq;

  localparam int DRAIN_TB = 16;
  localparam int B_SFP = 19, B_ACC = 18, B_DIV = 17, B_OFRD = 16;
  localparam int B_EXE = 7, B_KLD = 6, B_QRD = 5, B_QWR = 4;
  localparam int B_KRD = 3, B_KWR = 2, B_PRD = 1, B_PWR = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  n_q = 4'd0;
  logic [3:0]  n_k = 4'd0;
  logic        mem_req, busy, done;
  logic [19:0] inst;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  int last_done_cycle;
  int mreq_count, mreq_first, mreq_last;

  core_seq #(.DRAIN(DRAIN_TB)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .n_q_i(n_q), .n_k_i(n_k),
    .mem_req_o(mem_req), .busy_o(busy), .done_o(done), .inst_o(inst)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] bw(int b);
    logic [19:0] w;
    w = '0;
    w[b] = 1'b1;
    return w;
  endfunction

  function automatic logic [19:0] qk(int a);
    return 20'(a) << 12;
  endfunction

  function automatic logic [19:0] pa(int a);
    return 20'(a) << 8;
  endfunction

  // expected instruction stream of one pass, one entry per cycle
  function automatic void build(int nq, int nk);
    logic [19:0] w;
    exp_q.delete();
    for (int r = 0; r < nq; r++) exp_q.push_back(bw(B_QWR) | qk(r));
    for (int r = 0; r < nk; r++) exp_q.push_back(bw(B_KWR) | qk(r));
    for (int c = 0; c <= nk; c++) begin
      w = '0;
      if (c < nk) w |= bw(B_KRD) | qk(c);
      if (c > 0)  w |= bw(B_KLD);
      exp_q.push_back(w);
    end
    for (int c = 0; c <= nq; c++) begin
      w = '0;
      if (c < nq) w |= bw(B_QRD) | qk(c);
      if (c > 0)  w |= bw(B_EXE);
      exp_q.push_back(w);
    end
    for (int c = 0; c < DRAIN_TB; c++) exp_q.push_back('0);
    for (int c = 0; c <= nq; c++) begin
      w = '0;
      if (c < nq) w |= bw(B_OFRD);
      if (c > 0)  w |= bw(B_PWR) | pa(c - 1);
      exp_q.push_back(w);
    end
    for (int c = 0; c <= nq; c++) begin
      w = '0;
      if (c < nq) w |= bw(B_PRD) | pa(c);
      if (c > 0)  w |= bw(B_ACC);
      exp_q.push_back(w);
    end
    for (int r = 0; r < nq; r++) begin
      exp_q.push_back(bw(B_PRD) | pa(r));
      exp_q.push_back(bw(B_DIV));
      exp_q.push_back(bw(B_PWR) | bw(B_SFP) | pa(r));
    end
    exp_q.push_back('0);
  endfunction

  // run one pass and check every cycle; inj >= 0 pulses a bogus start at that stream index
  task automatic run_pass(int nq, int nk, int inj);
    int len;
    logic prev_krd;
    logic exp_mreq, exp_done;
    build(nq, nk);
    len = exp_q.size();
    last_done_cycle = -1;
    mreq_count = 0;
    mreq_first = -1;
    mreq_last = -1;
    @(posedge clk); #1;
    start = 1'b1; n_q = 4'(nq); n_k = 4'(nk);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || inst !== 20'h0) begin
      errors++;
      $display("FAIL accept_cycle busy=%b inst=%h required busy=0 inst=00000", busy, inst);
    end
    prev_krd = inst[B_KRD];
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (start) begin
        start = 1'b0;
        n_q = 4'(nq); n_k = 4'(nk);
      end
      exp_mreq = exp_q[k][B_QWR] | exp_q[k][B_KWR];
      exp_done = (k == len - 1);
      checks++;
      if (inst !== exp_q[k]) begin
        errors++;
        $display("FAIL inst nq=%0d nk=%0d idx=%0d got=%h required=%h", nq, nk, k, inst, exp_q[k]);
      end
      checks++;
      if (busy !== 1'b1 || mem_req !== exp_mreq || done !== exp_done) begin
        errors++;
        $display("FAIL flags idx=%0d busy/mem_req/done got=%b%b%b required=1%b%b",
                 k, busy, mem_req, done, exp_mreq, exp_done);
      end
      checks++;
      if ((inst[B_QRD] & inst[B_QWR]) || (inst[B_KRD] & inst[B_KWR]) ||
          (inst[B_PRD] & inst[B_PWR]) || inst[15] || inst[11] || inst[B_KLD] !== prev_krd) begin
        errors++;
        $display("FAIL invariant idx=%0d inst=%h prev_kmem_rd=%b required no rd/wr overlap, kload=prev_kmem_rd",
                 k, inst, prev_krd);
      end
      prev_krd = inst[B_KRD];
      if (done === 1'b1) last_done_cycle = k + 2;
      if (mem_req === 1'b1) begin
        mreq_count++;
        if (mreq_first < 0) mreq_first = k;
        mreq_last = k;
      end
      if (k == inj) begin
        start = 1'b1;
        n_q = 4'd1; n_k = 4'd1;
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || inst !== 20'h0) begin
      errors++;
      $display("FAIL post_pass busy=%b done=%b inst=%h required 0 0 00000", busy, done, inst);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1; n_q = 4'd2; n_k = 4'd2;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset inst=%h busy=%b done=%b mem_req=%b required all zero", inst, busy, done, mem_req);
    end
  endtask

  task automatic test_basic();
    run_pass(2, 3, -1);
    checks++;
    if (last_done_cycle !== 42) begin
      errors++;
      $display("FAIL done_latency got=%0d required=42", last_done_cycle);
    end
    checks++;
    if (mreq_count !== 5 || (mreq_last - mreq_first) !== 4) begin
      errors++;
      $display("FAIL mem_req_run count=%0d span=%0d required count=5 span=4",
               mreq_count, mreq_last - mreq_first);
    end
  endtask

  task automatic test_max();
    run_pass(8, 8, -1);
    checks++;
    if (last_done_cycle !== 8 + 8 + 9 + 9 + DRAIN_TB + 9 + 9 + 24 + 1 + 1) begin
      errors++;
      $display("FAIL done_latency_max got=%0d required=%0d", last_done_cycle,
               8 + 8 + 9 + 9 + DRAIN_TB + 9 + 9 + 24 + 1 + 1);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad_q[4] = '{4'd0, 4'd3, 4'd9, 4'd15};
    logic [3:0] bad_k[4] = '{4'd3, 4'd9, 4'd0, 4'd2};
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      start = 1'b1; n_q = bad_q[t]; n_k = bad_k[t];
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || inst !== 20'h0 || done !== 1'b0) begin
          errors++;
          $display("FAIL illegal_start nq=%0d nk=%0d busy=%b inst=%h done=%b required 0 00000 0",
                   bad_q[t], bad_k[t], busy, inst, done);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int inj;
    build(3, 2);
    inj = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (inj < 0 && exp_q[k][B_EXE]) inj = k;
    run_pass(3, 2, inj);
    run_pass(4, 1, -1);
  endtask

  task automatic test_reset_mid();
    int guard;
    @(posedge clk); #1;
    start = 1'b1; n_q = 4'd3; n_k = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (inst[B_OFRD] !== 1'b1 && guard < 200);
    checks++;
    if (inst[B_OFRD] !== 1'b1) begin
      errors++;
      $display("FAIL reach_ofifo timeout ofifo_rd=%b required=1", inst[B_OFRD]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (inst !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid inst=%h busy=%b done=%b mem_req=%b required all zero", inst, busy, done, mem_req);
    end
    // reset wins over a start in the same cycle
    reset = 1'b1; start = 1'b1; n_q = 4'd2; n_k = 4'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || inst !== 20'h0) begin
      errors++;
      $display("FAIL reset_priority busy=%b inst=%h required busy=0 inst=00000", busy, inst);
    end
    run_pass(3, 2, -1);
  endtask

  task automatic test_random();
    int nq, nk;
    for (int t = 0; t < 6; t++) begin
      nq = int'($urandom_range(1, 8));
      nk = int'($urandom_range(1, 8));
      run_pass(nq, nk, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_illegal();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
